// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory / register-bank datapath: default widths
// and the state encoding of the load-multiple engine.
package mem_sys_pkg;

    localparam int DataWDefault = 32;
    localparam int AddrWDefault = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/mem_to_breg_loader_if.sv
// Bundle of control, memory-read and register-bank-write signals of the
// load-multiple engine. The slave side is the loader, the master side is the
// controller plus memory and register bank.
//
// Handshake: start is a single-cycle request, honoured only while the loader
// is idle (busy=0, done=0); mem_base/reg_base/count are captured on that same
// edge. The loader then holds busy high until the cycle before done, and done
// is a single-cycle pulse with aborted valid alongside it. abort is a level
// looked at only while reads are still being issued. mem_rd_data is expected
// exactly one cycle after mem_dir is presented; each br_ewr=1 cycle is one
// register-bank write of br_din to br_dir.
interface mem_to_breg_loader_if
    import mem_sys_pkg::*;
#(
    parameter int DATA_W = DataWDefault,
    parameter int ADDR_W = AddrWDefault
) ();

    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   mem_base;
    logic [ADDR_W-1:0]   reg_base;
    logic [ADDR_W:0]     count;
    logic [ADDR_W-1:0]   mem_dir;
    logic [DATA_W-1:0]   mem_rd_data;
    logic [ADDR_W-1:0]   br_dir;
    logic [DATA_W-1:0]   br_din;
    logic                br_ewr;
    logic                busy;
    logic                done;
    logic                aborted;
    loader_state_t       dbgState;

    modport slave (
        input  start, abort, mem_base, reg_base, count, mem_rd_data,
        output mem_dir, br_dir, br_din, br_ewr, busy, done, aborted, dbgState
    );

    modport master (
        output start, abort, mem_base, reg_base, count, mem_rd_data,
        input  mem_dir, br_dir, br_din, br_ewr, busy, done, aborted, dbgState
    );

endinterface

// File: rtl/mem_to_breg_loader.sv
// Load-multiple engine: streams a block of words from the data memory read
// port into the register bank write port, one word per cycle after a
// one-cycle fill while the memory read completes.
module mem_to_breg_loader
    import mem_sys_pkg::*;
#(
    parameter int DATA_W  = DataWDefault,
    parameter int ADDR_W  = AddrWDefault,
    parameter bit SKIP_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_to_breg_loader_if.slave  bus
);

    localparam int CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] MaxCount = CntW'(2 ** ADDR_W);

    loader_state_t      state;
    logic [CntW-1:0]    remaining;     // reads still to issue after the current one
    logic [ADDR_W-1:0]  wrPtr;         // register address of the next write slot
    logic [ADDR_W-1:0]  memDir;
    logic [ADDR_W-1:0]  brDir;
    logic               brEwr;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [CntW-1:0]    clampedCount;
    logic               slotWrites;
    logic [DATA_W-1:0]  rdData;

    // Requests longer than the bank are truncated to a full-bank copy.
    always_comb clampedCount = (bus.count > MaxCount) ? MaxCount : bus.count;

    // A slot aimed at register 0 keeps its timing but does not write when r0 is hard-wired.
    always_comb slotWrites = !(SKIP_R0 && (wrPtr == '0));

    // Issue/write sequencer: the word read in one cycle is written in the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            wrPtr     <= '0;
            memDir    <= '0;
            brDir     <= '0;
            brEwr     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            brEwr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (clampedCount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            memDir    <= bus.mem_base;
                            wrPtr     <= bus.reg_base;
                            remaining <= clampedCount - CntW'(1);
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // The read presented this cycle is discarded; the write
                        // of the previous read is already on the bank port.
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        brEwr <= slotWrites;
                        brDir <= wrPtr;
                        wrPtr <= wrPtr + ADDR_W'(1);
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end else begin
                            memDir    <= memDir + ADDR_W'(1);
                            remaining <= remaining - CntW'(1);
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write data is the memory read data passed straight through.
    assign rdData       = bus.mem_rd_data;
    assign bus.br_din   = rdData;
    assign bus.mem_dir  = memDir;
    assign bus.br_dir   = brDir;
    assign bus.br_ewr   = brEwr;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.aborted  = aborted;
    assign bus.dbgState = state;

endmodule

// File: tb/tb_mem_to_breg_loader.sv
// Directed bench for the load-multiple engine: behavioural 32x32 memory with
// a registered read, a write logger on the register-bank port, and checks of
// write order/timing, done latency, busy window, abort and reset behaviour.
module tb_mem_to_breg_loader;
    import mem_sys_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_to_breg_loader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_to_breg_loader #(.DATA_W(32), .ADDR_W(5), .SKIP_R0(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Behavioural memory with one-cycle registered read.
    logic [31:0] mem [32];
    always @(posedge clk) bus.mem_rd_data <= mem[bus.mem_dir];

    // Free-running cycle counter; cycle k of a transfer is cycAbs - e0Val + 1.
    int cycAbs = 0;
    always @(posedge clk) cycAbs <= cycAbs + 1;

    int e0Val = 0;
    int passCnt = 0;
    int totalCnt = 0;

    // Register-bank write log and per-transfer observations.
    logic [44:0] wrQ[$];
    logic [44:0] expQ[$];
    int          doneCnt = 0;
    int          doneK = 0;
    logic        doneAb = 1'b0;
    int          busyCnt = 0;
    int          firstBusyK = 0;
    int          lastBusyK = 0;
    logic [4:0]  memDirAt [64];

    function automatic logic [44:0] packWr(input int k, input logic [4:0] dir, input logic [31:0] d);
        return {8'(k), dir, d};
    endfunction

    // Monitor on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        int k;
        k = cycAbs - e0Val + 1;
        if (bus.br_ewr === 1'b1) wrQ.push_back(packWr(k, bus.br_dir, bus.br_din));
        if (bus.done === 1'b1) begin
            doneCnt = doneCnt + 1;
            doneK   = k;
            doneAb  = bus.aborted;
        end
        if (bus.busy === 1'b1) begin
            busyCnt = busyCnt + 1;
            lastBusyK = k;
            if (firstBusyK == 0) firstBusyK = k;
        end
        if (k >= 1 && k < 64) memDirAt[k] = bus.mem_dir;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt = totalCnt + 1;
        assert (obs === exp) passCnt = passCnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Driver: present a start request for one cycle; returns inside cycle 1.
    task automatic startOp(input logic [4:0] mb, input logic [4:0] rb, input logic [5:0] cnt,
                           input logic withAbort);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.abort    = withAbort;
        bus.mem_base = mb;
        bus.reg_base = rb;
        bus.count    = cnt;
        @(posedge clk); #1;
        e0Val = cycAbs;
        wrQ.delete();
        doneCnt = 0; doneK = 0; doneAb = 1'b0;
        busyCnt = 0; firstBusyK = 0; lastBusyK = 0;
        for (int i = 0; i < 64; i++) memDirAt[i] = 5'h1f;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk); #1;
            if (doneCnt != 0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
    endtask

    // Scoreboard: compare logged writes with the expected queue, then empty it.
    task automatic compareWrites(input string tag);
        check({tag, "_nwr"}, 64'(wrQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < wrQ.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(wrQ[i]), 64'(expQ[i]));
        expQ.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_mem_dir"}, 64'(bus.mem_dir), 64'(0));
        check({tag, "_br_dir"},  64'(bus.br_dir),  64'(0));
        check({tag, "_br_ewr"},  64'(bus.br_ewr),  64'(0));
        check({tag, "_busy"},    64'(bus.busy),    64'(0));
        check({tag, "_done"},    64'(bus.done),    64'(0));
        check({tag, "_aborted"}, 64'(bus.aborted), 64'(0));
        check({tag, "_state"},   64'(bus.dbgState), 64'(IDLE));
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] m;
        for (int i = 0; i < 32; i++) mem[i] = 32'h5000_0000 | 32'(i);
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.mem_base = '0; bus.reg_base = '0; bus.count = '0;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");

        // 1: mem[4..6] -> r8..r10
        mem[4] = 32'hA000_000A; mem[5] = 32'hB000_000B; mem[6] = 32'hC000_000C;
        startOp(5'd4, 5'd8, 6'd3, 1'b0);
        waitDone("t1", 20);
        check("t1_done_k", 64'(doneK), 64'(5));
        check("t1_aborted", 64'(doneAb), 64'(0));
        check("t1_busy_cnt", 64'(busyCnt), 64'(4));
        check("t1_busy_first", 64'(firstBusyK), 64'(1));
        check("t1_busy_last", 64'(lastBusyK), 64'(4));
        check("t1_rd1", 64'(memDirAt[1]), 64'(4));
        check("t1_rd3", 64'(memDirAt[3]), 64'(6));
        expQ.push_back(packWr(2, 5'd8, 32'hA000_000A));
        expQ.push_back(packWr(3, 5'd9, 32'hB000_000B));
        expQ.push_back(packWr(4, 5'd10, 32'hC000_000C));
        compareWrites("t1");

        // 2: both pointers wrap; the r0 slot is suppressed
        mem[30] = 32'h3030_3030; mem[31] = 32'h3131_3131;
        mem[0]  = 32'h0000_F00D; mem[1]  = 32'h0101_0101;
        startOp(5'd30, 5'd31, 6'd4, 1'b0);
        waitDone("t2", 20);
        check("t2_done_k", 64'(doneK), 64'(6));
        check("t2_rd1", 64'(memDirAt[1]), 64'(30));
        check("t2_rd2", 64'(memDirAt[2]), 64'(31));
        check("t2_rd3", 64'(memDirAt[3]), 64'(0));
        check("t2_rd4", 64'(memDirAt[4]), 64'(1));
        expQ.push_back(packWr(2, 5'd31, 32'h3030_3030));
        expQ.push_back(packWr(4, 5'd1, 32'h0000_F00D));
        expQ.push_back(packWr(5, 5'd2, 32'h0101_0101));
        compareWrites("t2");

        // 3a: zero-length request completes in cycle 1, mem_dir untouched (last read was 1)
        startOp(5'd7, 5'd3, 6'd0, 1'b0);
        waitDone("t3a", 10);
        check("t3a_done_k", 64'(doneK), 64'(1));
        check("t3a_aborted", 64'(doneAb), 64'(0));
        check("t3a_busy_cnt", 64'(busyCnt), 64'(0));
        check("t3a_mem_dir", 64'(memDirAt[1]), 64'(1));
        compareWrites("t3a");

        // 3b: count 40 clamps to 32 slots; the slot landing on r0 does not write
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | (32'(i) * 32'h0101);
        startOp(5'd5, 5'd1, 6'd40, 1'b0);
        waitDone("t3b", 60);
        check("t3b_done_k", 64'(doneK), 64'(34));
        check("t3b_busy_cnt", 64'(busyCnt), 64'(33));
        r = 5'd1; m = 5'd5;
        for (int j = 0; j < 32; j++) begin
            if (r != 5'd0) expQ.push_back(packWr(j + 2, r, mem[m]));
            r = r + 5'd1; m = m + 5'd1;
        end
        compareWrites("t3b");

        // 4: abort in cycle 4 of a 10-word copy
        startOp(5'd2, 5'd12, 6'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        waitDone("t4", 20);
        check("t4_done_k", 64'(doneK), 64'(5));
        check("t4_aborted", 64'(doneAb), 64'(1));
        expQ.push_back(packWr(2, 5'd12, mem[2]));
        expQ.push_back(packWr(3, 5'd13, mem[3]));
        expQ.push_back(packWr(4, 5'd14, mem[4]));
        compareWrites("t4");

        // 4b: next start, with abort in the same cycle, runs normally
        startOp(5'd20, 5'd20, 6'd2, 1'b1);
        waitDone("t4b", 20);
        check("t4b_done_k", 64'(doneK), 64'(4));
        check("t4b_aborted", 64'(doneAb), 64'(0));
        expQ.push_back(packWr(2, 5'd20, mem[20]));
        expQ.push_back(packWr(3, 5'd21, mem[21]));
        compareWrites("t4b");

        // 5: start re-pulsed in cycles 2 and 3 is ignored
        startOp(5'd9, 5'd16, 6'd5, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mem_base = 5'd0; bus.reg_base = 5'd0; bus.count = 6'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitDone("t5", 20);
        check("t5_done_k", 64'(doneK), 64'(7));
        repeat (5) @(negedge clk);
        check("t5_done_cnt", 64'(doneCnt), 64'(1));
        for (int j = 0; j < 5; j++) expQ.push_back(packWr(j + 2, 5'(16 + j), mem[9 + j]));
        compareWrites("t5");

        // 6: reset in cycle 3 of an 8-word copy
        startOp(5'd0, 5'd4, 6'd8, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("t6_rst");
        repeat (4) @(negedge clk);
        check("t6_no_done", 64'(doneCnt), 64'(0));
        startOp(5'd14, 5'd25, 6'd2, 1'b0);
        waitDone("t6b", 20);
        check("t6b_done_k", 64'(doneK), 64'(4));
        expQ.push_back(packWr(2, 5'd25, mem[14]));
        expQ.push_back(packWr(3, 5'd26, mem[15]));
        compareWrites("t6b");

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
